soc_top: RTL and testbench

Minimal FPGA top level: derives an internal power-on reset from the oscillator clock and drives two status LEDs. It contains a single-master I2C writer that sends a fixed 3-byte register-init transaction after reset. It is the board-level root of the design, with no external reset pin.

---
 rtl/soc_top.sv | 169 ++++++++++++++++
 tb/tb_soc_top.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/soc_top.sv
// Board root: power-on reset, heartbeat/status LEDs and a one-shot I2C writer that sends
// {I2C_ADDR,W}, REG_ADDR, REG_DATA once after power-up, then parks in DONE or ERROR.
module soc_top #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned LED_DIV_BITS = 22,
  parameter logic [6:0]  I2C_ADDR     = 7'h39,
  parameter logic [7:0]  REG_ADDR     = 8'h41,
  parameter logic [7:0]  REG_DATA     = 8'h10
) (
  input  logic osc_clk,
  output logic led1,
  output logic led2,
  output logic i2c_scl,
  inout  wire  i2c_sda
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [LED_DIV_BITS-1:0] LED_ONE = LED_DIV_BITS'(1);
  localparam logic [7:0] ADDR_BYTE = {I2C_ADDR, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE, S_ERROR
  } state_t;

  // The power-up value is the only source of reset; there is no reset pin.
  logic [3:0] por_cnt_q = 4'd0;
  logic       reset;

  assign reset = (por_cnt_q != 4'd15);

  always_ff @(posedge osc_clk) begin
    if (reset) por_cnt_q <= por_cnt_q + 4'd1;
  end

  logic [LED_DIV_BITS-1:0] led_cnt_q, led_cnt_d;
  logic [DIV_W-1:0]        div_q;
  logic                    tick;

  assign led_cnt_d = led_cnt_q + LED_ONE;
  assign tick      = (div_q == DIV_LAST);

  always_ff @(posedge osc_clk) begin
    if (reset) begin
      led_cnt_q <= '0;
      div_q     <= '0;
    end else begin
      led_cnt_q <= led_cnt_d;
      div_q     <= tick ? '0 : div_q + DIV_ONE;
    end
  end

  function automatic logic [7:0] byte_at(input logic [1:0] idx);
    case (idx)
      2'd0:    byte_at = ADDR_BYTE;
      2'd1:    byte_at = REG_ADDR;
      default: byte_at = REG_DATA;
    endcase
  endfunction

  state_t     state_q;
  logic [1:0] phase_q, byte_q;
  logic [2:0] bit_q;
  logic       nack_q, scl_q, sda_low_q, led2_q;
  logic [7:0] cur_byte, nxt_byte;

  assign cur_byte = byte_at(byte_q);
  assign nxt_byte = byte_at(byte_q + 2'd1);

  // Each tick moves to the next phase and registers that phase's SCL/SDA levels.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      byte_q    <= '0;
      bit_q     <= '0;
      nack_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
      led2_q    <= 1'b0;
    end else begin
      led2_q <= (state_q == S_DONE) | ((state_q == S_ERROR) & led_cnt_d[LED_DIV_BITS-2]);
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            state_q   <= S_START;
            phase_q   <= 2'd0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
          end
          S_START: begin
            if (phase_q == 2'd0) begin
              phase_q   <= 2'd1;
              sda_low_q <= 1'b1;
            end else begin
              state_q   <= S_BIT;
              phase_q   <= 2'd0;
              byte_q    <= 2'd0;
              bit_q     <= 3'd7;
              scl_q     <= 1'b0;
              sda_low_q <= ~ADDR_BYTE[7];
            end
          end
          S_BIT: begin
            phase_q <= phase_q + 2'd1;
            case (phase_q)
              2'd0: scl_q <= 1'b0;
              2'd1: scl_q <= 1'b1;
              2'd2: scl_q <= 1'b1;
              default: begin
                scl_q <= 1'b0;
                if (bit_q == 3'd0) begin
                  state_q   <= S_ACK;
                  sda_low_q <= 1'b0;
                end else begin
                  bit_q     <= bit_q - 3'd1;
                  sda_low_q <= ~cur_byte[bit_q - 3'd1];
                end
              end
            endcase
          end
          S_ACK: begin
            phase_q <= phase_q + 2'd1;
            case (phase_q)
              2'd0: scl_q <= 1'b0;
              2'd1: scl_q <= 1'b1;
              // Only a solid low is an ACK; high, floating or unknown all count as NACK.
              2'd2: begin
                if (i2c_sda == 1'b0) nack_q <= 1'b0;
                else                 nack_q <= 1'b1;
              end
              default: begin
                scl_q <= 1'b0;
                if (nack_q || byte_q == 2'd2) begin
                  state_q   <= S_STOP;
                  sda_low_q <= 1'b1;
                end else begin
                  state_q   <= S_BIT;
                  byte_q    <= byte_q + 2'd1;
                  bit_q     <= 3'd7;
                  sda_low_q <= ~nxt_byte[7];
                end
              end
            endcase
          end
          S_STOP: begin
            phase_q <= phase_q + 2'd1;
            case (phase_q)
              2'd0:    scl_q <= 1'b1;
              2'd1:    sda_low_q <= 1'b0;
              default: state_q <= nack_q ? S_ERROR : S_DONE;
            endcase
          end
          default: begin
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;
  assign i2c_scl = scl_q;
  assign led1    = led_cnt_q[LED_DIV_BITS-1];
  assign led2    = led2_q;

endmodule

// File: tb/tb_soc_top.sv
// Four soc_top instances share one clock, each with its own bus, pull-up and slave policy;
// a bus monitor decodes START/STOP/bytes/ACKs and a cycle-level model predicts LEDs and end times.
module tb_soc_top;
  localparam int CLK_DIV  = 4;
  localparam int LED_BITS = 4;
  localparam int NI       = 4;
  localparam int T_RUN    = 10400;

  logic osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  int cyc = 0;
  always @(posedge osc_clk) cyc <= cyc + 1;

  wire  [NI-1:0] scl_w, sda_w, led1_w, led2_w;
  logic [NI-1:0] slv_low = '0;
  int            nack_at [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wire sda;
    pullup (sda);
    assign sda      = slv_low[g] ? 1'b0 : 1'bz;
    assign sda_w[g] = sda;
    soc_top #(.CLK_DIV(CLK_DIV), .LED_DIV_BITS(LED_BITS)) u_dut (
      .osc_clk (osc_clk),
      .led1    (led1_w[g]),
      .led2    (led2_w[g]),
      .i2c_scl (scl_w[g]),
      .i2c_sda (sda)
    );
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus monitor and slave: samples on the falling clock edge, far from DUT updates.
  int         starts [NI], stops [NI], rises [NI], nrx [NI];
  int         start_cyc [NI], stop_cyc [NI], last_rise [NI], dly [NI];
  logic       pscl [NI], psda [NI], pend [NI];
  logic [7:0] sh [NI];
  logic [7:0] rxb [NI][4];
  logic       rxack [NI][4];
  int         pos, idx;

  initial begin
    for (int i = 0; i < NI; i++) begin
      starts[i] = 0; stops[i] = 0; rises[i] = 0; nrx[i] = 0;
      start_cyc[i] = -1; stop_cyc[i] = -1; last_rise[i] = -1; dly[i] = 0;
      pscl[i] = 1'b1; psda[i] = 1'b1; pend[i] = 1'b0; sh[i] = '0;
    end
  end

  always @(negedge osc_clk) begin
    if (cyc >= 2) begin
      for (int i = 0; i < NI; i++) begin
        if (pscl[i] && scl_w[i] && psda[i] && !sda_w[i]) begin
          starts[i]++;
          start_cyc[i] = cyc;
        end
        if (pscl[i] && scl_w[i] && !psda[i] && sda_w[i]) begin
          stops[i]++;
          stop_cyc[i] = cyc;
        end
        if (!pscl[i] && scl_w[i]) begin
          rises[i]++;
          last_rise[i] = cyc;
          pos = (rises[i] - 1) % 9;
          idx = (rises[i] - 1) / 9;
          if (pos < 8) sh[i] = {sh[i][6:0], sda_w[i]};
          if (pos == 7 && idx < 4) rxb[i][idx] = sh[i];
          if (pos == 8 && idx < 4) begin
            rxack[i][idx] = !sda_w[i];
            nrx[i]++;
          end
        end
        if (pscl[i] && !scl_w[i]) begin
          if (rises[i] % 9 == 8 && rises[i] / 9 < nack_at[i]) begin
            pend[i] = 1'b1;
            dly[i]  = $urandom_range(0, 3);
          end
          if (rises[i] % 9 == 0) slv_low[i] = 1'b0;
        end
        if (pend[i]) begin
          if (dly[i] == 0) begin
            slv_low[i] = 1'b1;
            pend[i]    = 1'b0;
          end else begin
            dly[i]--;
          end
        end
        pscl[i] = scl_w[i];
        psda[i] = sda_w[i];
      end
    end
  end

  // Reference: LED counter value after rising edge k (held through edge 15, counts from edge 16).
  function automatic int led_cnt(input int k);
    return (k <= 15) ? 0 : ((k - 15) % (1 << LED_BITS));
  endfunction

  logic [7:0] exp_b [3];
  int nb [NI], t_end [NI];
  int t_first, kc;
  logic succ;

  initial begin
    exp_b[0] = 8'h72; exp_b[1] = 8'h41; exp_b[2] = 8'h10;
    nack_at[0] = 3;                      // every byte acknowledged
    nack_at[1] = 0;                      // no slave: address NACKed by the pull-up
    nack_at[2] = 2;                      // last data byte NACKed
    nack_at[3] = $urandom_range(0, 3);   // random policy
    t_first = 15 + CLK_DIV;
    for (int i = 0; i < NI; i++) begin
      nb[i]    = (nack_at[i] >= 3) ? 3 : nack_at[i] + 1;
      t_end[i] = t_first + 2 * CLK_DIV + nb[i] * 36 * CLK_DIV + 3 * CLK_DIV;
    end

    for (int k = 1; k <= T_RUN; k++) begin
      @(posedge osc_clk);
      #2;
      kc = cyc;
      for (int i = 0; i < NI; i++) begin
        succ = (nack_at[i] >= 3);
        if (kc <= 15) begin
          chk($sformatf("por_led1[%0d]", i), led1_w[i], 1'b0);
          chk($sformatf("por_led2[%0d]", i), led2_w[i], 1'b0);
          chk($sformatf("por_scl[%0d]", i),  scl_w[i],  1'b1);
          chk($sformatf("por_sda[%0d]", i),  sda_w[i],  1'b1);
        end
        if (kc % 3 == 0 || kc < 64)
          chk($sformatf("led1[%0d]", i), led1_w[i], (led_cnt(kc) >> (LED_BITS - 1)) & 1);
        if (kc > 15 && kc < t_end[i] && (kc % 11 == 0 || kc == t_end[i] - 1))
          chk($sformatf("led2_busy[%0d]", i), led2_w[i], 1'b0);
        if (kc > t_end[i] && (kc - t_end[i]) % 5 == 1) begin
          if (succ) chk($sformatf("led2_done[%0d]", i), led2_w[i], 1'b1);
          else      chk($sformatf("led2_blink[%0d]", i), led2_w[i],
                        (led_cnt(kc) >> (LED_BITS - 2)) & 1);
        end
        if (kc > t_end[i] && (kc - t_end[i]) % 97 == 3) begin
          chk($sformatf("idle_scl[%0d]", i), scl_w[i], 1'b1);
          chk($sformatf("idle_sda[%0d]", i), sda_w[i], 1'b1);
        end
      end
    end

    for (int i = 0; i < NI; i++) begin
      chk($sformatf("starts[%0d]", i), starts[i], 1);
      chk($sformatf("start_cyc[%0d]", i), start_cyc[i], t_first + CLK_DIV);
      chk($sformatf("stops[%0d]", i), stops[i], 1);
      chk($sformatf("stop_cyc[%0d]", i), stop_cyc[i], t_end[i] - CLK_DIV);
      chk($sformatf("nbytes[%0d]", i), nrx[i], nb[i]);
      chk($sformatf("scl_rises[%0d]", i), rises[i], 9 * nb[i] + 1);
      chk($sformatf("last_rise_before_end[%0d]", i), last_rise[i] < t_end[i], 1'b1);
      for (int b = 0; b < 3; b++) begin
        if (b < nb[i]) begin
          chk($sformatf("byte%0d[%0d]", b, i), rxb[i][b], exp_b[b]);
          chk($sformatf("ack%0d[%0d]", b, i), rxack[i][b], b < nack_at[i]);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
